// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared MLP constants and types for the output argmax collector
package mlp_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 16;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);
    localparam int Q_FRAC_BITS = 8;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [CLASS_W-1:0]        class_idx_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_RESULT  = 1'b1
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - combinational signed running-max step for one score beat
module argmax_cmp #(
    parameter int DW = 16,
    parameter int IW = 4
) (
    input  logic          i_first,
    input  logic [DW-1:0] i_data,
    input  logic [IW-1:0] i_idx,
    input  logic [DW-1:0] i_cur_max,
    input  logic [IW-1:0] i_cur_idx,
    output logic          o_take_new,
    output logic [DW-1:0] o_max_next,
    output logic [IW-1:0] o_idx_next
);
    import mlp_pkg::*;

    // Strictly-greater signed compare so ties keep the earlier (lower) index
    always_comb begin
        o_take_new = i_first || ($signed(i_data) > $signed(i_cur_max));
        o_max_next = o_take_new ? i_data : i_cur_max;
        o_idx_next = o_take_new ? i_idx  : i_cur_idx;
    end

endmodule

// File: rtl/output_argmax_collector.sv
// rtl/output_argmax_collector.sv - collects output-layer scores and emits argmax digit (optional ARGMAX_SCORE_OUT_EN adds out_score)
module output_argmax_collector #(
    parameter int NUM_CLASSES = mlp_pkg::NUM_CLASSES,
    parameter int DW          = mlp_pkg::SCORE_W,
    parameter int IW          = mlp_pkg::CLASS_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [IW-1:0] in_idx,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_digit,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic [DW-1:0] out_score,
`endif
    output logic          err_seq
);
    import mlp_pkg::*;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_cnt;
    logic [DW-1:0] r_max;
    logic [IW-1:0] r_max_idx;
    logic [IW-1:0] r_digit;
    logic          r_err;

    logic          w_accept;
    logic          w_cnt_last;
    logic          w_terminal;
    logic          w_beat_err;
    logic          w_take_new;
    logic [DW-1:0] w_max_next;
    logic [IW-1:0] w_idx_next;

    assign w_accept   = in_valid && in_ready;
    assign w_cnt_last = (r_cnt == LAST_IDX);
    assign w_terminal = w_accept && (in_last || w_cnt_last);
    // Any of: wrong index, early last, missing last
    assign w_beat_err = (in_idx != r_cnt) || (in_last && !w_cnt_last) || (w_cnt_last && !in_last);

    // The running max is indexed by beat position, not by the (possibly wrong) in_idx
    argmax_cmp #(
        .DW (DW),
        .IW (IW)
    ) u_cmp (
        .i_first    (r_cnt == '0),
        .i_data     (in_data),
        .i_idx      (r_cnt),
        .i_cur_max  (r_max),
        .i_cur_idx  (r_max_idx),
        .o_take_new (w_take_new),
        .o_max_next (w_max_next),
        .o_idx_next (w_idx_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: collect until the terminal beat, hold result until it is taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_terminal) w_state_next = ST_RESULT;
            ST_RESULT:  if (out_ready)  w_state_next = ST_COLLECT;
            default:    w_state_next = ST_COLLECT;
        endcase
    end

    // Handshake outputs decoded from state; ready is forced low while in reset
    always_comb begin
        in_ready  = (r_state == ST_COLLECT) && !reset;
        out_valid = (r_state == ST_RESULT);
    end

    // Beat counter and running maximum, advanced on every accepted beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            r_cnt     <= w_terminal ? '0 : r_cnt + 1'b1;
            r_max     <= w_max_next;
            r_max_idx <= w_idx_next;
        end
    end

    // Result register captured on the terminal beat and held under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= '0;
        end else if (w_terminal) begin
            r_digit <= w_idx_next;
        end
    end

    assign out_digit = r_digit;

`ifdef ARGMAX_SCORE_OUT_EN
    logic [DW-1:0] r_score;

    // Winning score captured alongside the digit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_score <= '0;
        end else if (w_terminal) begin
            r_score <= w_max_next;
        end
    end

    assign out_score = r_score;
`endif

    // Sticky sequencing error, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && w_beat_err) begin
            r_err <= 1'b1;
        end
    end

    assign err_seq = r_err;

endmodule

// File: tb/tb_output_argmax_collector.sv
// tb/tb_output_argmax_collector.sv - self-checking bench for output_argmax_collector
module tb_output_argmax_collector;

    localparam int NC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_idx = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_digit;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [15:0] out_score;
`endif
    logic        err_seq;

    always #5 clk = ~clk;

    output_argmax_collector dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
`ifdef ARGMAX_SCORE_OUT_EN
        .out_score (out_score),
`endif
        .err_seq   (err_seq)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    int                  m_cnt = 0;
    logic signed [15:0]  m_scores[$];
    int                  exp_digit_q[$];
    logic [15:0]         exp_score_q[$];
    bit                  m_err = 1'b0;
    bit                  rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int argmax_of(input logic signed [15:0] s[$]);
        int best = 0;
        for (int i = 1; i < s.size(); i++)
            if (s[i] > s[best]) best = i;
        return best;
    endfunction

    task automatic model_accept(input logic signed [15:0] d, input int idx, input bit last);
        int b;
        if (idx != m_cnt || (last && m_cnt != NC - 1) || (m_cnt == NC - 1 && !last)) m_err = 1'b1;
        m_scores.push_back(d);
        if (last || m_cnt == NC - 1) begin
            b = argmax_of(m_scores);
            exp_digit_q.push_back(b);
            exp_score_q.push_back(m_scores[b]);
            m_scores.delete();
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Single compare process: every cycle, DUT outputs against the model
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("in_ready", {31'd0, in_ready}, {31'd0, exp_digit_q.size() == 0});
                chk("out_valid", {31'd0, out_valid}, {31'd0, exp_digit_q.size() != 0});
                if (exp_digit_q.size() != 0) begin
                    chk("out_digit", {28'd0, out_digit}, exp_digit_q[0]);
`ifdef ARGMAX_SCORE_OUT_EN
                    chk("out_score", {16'd0, out_score}, {16'd0, exp_score_q[0]});
`endif
                end
                chk("err_seq", {31'd0, err_seq}, {31'd0, m_err});
            end
            hs = !reset && exp_digit_q.size() != 0 && out_ready;
            @(posedge clk);
            if (hs && exp_digit_q.size() != 0) begin
                void'(exp_digit_q.pop_front());
                void'(exp_score_q.pop_front());
            end
        end
    end

    // Random downstream backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk);
        m_cnt = 0;
        m_scores.delete();
        exp_digit_q.delete();
        exp_score_q.delete();
        m_err = 1'b0;
        repeat (cycles - 1) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input int idx, input bit last, input int gap);
        bit acc = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_idx   = 4'(idx);
        in_last  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = !reset && exp_digit_q.size() == 0;
            @(posedge clk);
            if (acc) begin
                model_accept(d, idx, last);
                break;
            end
        end
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL beat_accept_timeout: got no accept expected accept within 200 cycles");
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic send_frame(input logic [15:0] s[NC], input int nbeats, input int last_pos,
                              input int gap_max, input int bad_idx);
        for (int i = 0; i < nbeats; i++)
            send_beat(s[i], (i == bad_idx) ? (i ^ 1) : i, i == last_pos,
                      (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    endtask

    // Wait for the result and pin it against a hand-computed literal
    task automatic wait_result(input string name, input int exp_digit, input bit exp_err, input int max_lat);
        int t;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_latency"}, (t <= max_lat) ? 32'd1 : 32'd0, 32'd1);
        chk({name, "_digit"}, {28'd0, out_digit}, exp_digit);
        chk({name, "_err"}, {31'd0, err_seq}, {31'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s[NC];
        int nb, lp, bad;
        int t1v[NC] = '{1, 5, -3, 9, 2, 0, 0, 0, 0, -1};

        do_reset(3);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_digit", {28'd0, out_digit}, 32'd0);
        chk("rst_err_seq", {31'd0, err_seq}, 32'd0);
`ifdef ARGMAX_SCORE_OUT_EN
        chk("rst_out_score", {16'd0, out_score}, 32'd0);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Test 1: basic frame, max 9.0 at idx 3
        for (int i = 0; i < NC; i++) s[i] = 16'(t1v[i] * 256);
        send_frame(s, NC, NC - 1, 0, -1);
        wait_result("t1", 3, 1'b0, 0);

        // Test 2: all equal negative scores, tie keeps idx 0
        for (int i = 0; i < NC; i++) s[i] = 16'hFF00;
        send_frame(s, NC, NC - 1, 0, -1);
`ifdef ARGMAX_SCORE_OUT_EN
        @(negedge clk);
        chk("t2_score", {16'd0, out_score}, 32'h0000FF00);
        @(posedge clk);
        #1;
`endif
        wait_result("t2", 0, 1'b0, 1);

        // Test 3: result held 5 cycles under backpressure, accepted on the 6th
        out_ready = 1'b0;
        for (int i = 0; i < NC; i++) s[i] = 16'(i == 5 ? 16'h0300 : 16'h0100);
        send_frame(s, NC, NC - 1, 0, -1);
        wait_result("t3", 5, 1'b0, 0);
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
            chk("t3_hold_digit", {28'd0, out_digit}, 32'd5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_c6_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("t3_after_ready", {31'd0, in_ready}, 32'd1);
        chk("t3_after_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Test 4: early last on idx 4, max at idx 2; error is sticky
        s = '{16'h0100, 16'h0200, 16'h0700, 16'hFE00, 16'h0600, 0, 0, 0, 0, 0};
        send_frame(s, 5, 4, 0, -1);
        wait_result("t4", 2, 1'b1, 0);
        for (int i = 0; i < NC; i++) s[i] = 16'(t1v[i] * 256);
        send_frame(s, NC, NC - 1, 0, -1);
        wait_result("t4_clean", 3, 1'b1, 0);

        // Test 5: reset mid-frame, then a full frame with max at idx 7
        for (int i = 0; i < NC; i++) s[i] = 16'h0400;
        send_frame(s, 6, -1, 0, -1);
        do_reset(2);
        for (int i = 0; i < NC; i++) s[i] = 16'(i == 7 ? 16'h0500 : 16'h0080 * i);
        send_frame(s, NC, NC - 1, 0, -1);
        wait_result("t5", 7, 1'b0, 0);

        // Test 6: extremes with random gaps and backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            s[i] = 16'($urandom);
            if (s[i] == 16'h7FFF) s[i] = 16'h7FFE;
        end
        s[0] = 16'h8000;
        s[NC-1] = 16'h7FFF;
        send_frame(s, NC, NC - 1, 3, -1);
        wait_result("t6", 9, 1'b0, 0);

        // Random frames: narrow score range for ties, occasional sequencing errors
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NC; i++) s[i] = 16'((int'($urandom_range(0, 7)) - 4) * 128);
            nb  = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(1, NC)) : NC;
            lp  = nb - 1;
            if (nb == NC && $urandom_range(0, 5) == 0) lp = -1;
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            send_frame(s, nb, lp, 2, bad);
        end

        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
